vga_timing_core: RTL and testbench

//   Parameterised VGA raster timing generator; the stage directly upstream of the pixel/pattern logic.

---
 rtl/vga_timing_pkg.sv | 22 ++
 rtl/vga_axis_counter.sv | 48 ++++
 rtl/vga_timing_core.sv | 81 ++++++++
 tb/tb_vga_timing_core.sv | 111 +++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Shared constants for the VGA raster timing generator: 640x480@60 defaults,
// sync polarity encodings and the coordinate width.
package vga_timing_pkg;

    localparam int POS_W = 10;

    localparam int H_DISPLAY_DEF = 640;
    localparam int H_FRONT_DEF   = 16;
    localparam int H_SYNC_DEF    = 96;
    localparam int H_BACK_DEF    = 48;
    localparam int H_TOTAL_DEF   = H_DISPLAY_DEF + H_FRONT_DEF + H_SYNC_DEF + H_BACK_DEF;

    localparam int V_DISPLAY_DEF = 480;
    localparam int V_FRONT_DEF   = 10;
    localparam int V_SYNC_DEF    = 2;
    localparam int V_BACK_DEF    = 33;
    localparam int V_TOTAL_DEF   = V_DISPLAY_DEF + V_FRONT_DEF + V_SYNC_DEF + V_BACK_DEF;

    localparam logic SYNC_ACTIVE_LOW  = 1'b0;
    localparam logic SYNC_ACTIVE_HIGH = 1'b1;

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping position counter with a registered sync window decode.
// pos_next is exported so the top can decode cross-axis signals without skew.
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int   DISPLAY  = H_DISPLAY_DEF,
    parameter int   FRONT    = H_FRONT_DEF,
    parameter int   SYNC     = H_SYNC_DEF,
    parameter int   BACK     = H_BACK_DEF,
    parameter logic SYNC_POL = SYNC_ACTIVE_LOW
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [POS_W-1:0] pos,
    output logic [POS_W-1:0] pos_next,
    output logic             wrap,
    output logic             sync
);

    localparam int TOTAL = DISPLAY + FRONT + SYNC + BACK;
    localparam logic [POS_W-1:0] LAST    = POS_W'(TOTAL - 1);
    localparam logic [POS_W-1:0] SYNC_LO = POS_W'(DISPLAY + FRONT);
    localparam logic [POS_W-1:0] SYNC_HI = POS_W'(DISPLAY + FRONT + SYNC - 1);

    logic at_end;

    // >= rather than == so a forced out-of-range value recovers on the next step
    assign at_end = (pos >= LAST);
    assign wrap   = inc & at_end;

    always_comb begin
        pos_next = pos;
        if (inc)
            pos_next = at_end ? '0 : pos + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pos  <= '0;
            sync <= ~SYNC_POL;
        end else begin
            pos  <= pos_next;
            sync <= (pos_next >= SYNC_LO && pos_next <= SYNC_HI) ? SYNC_POL : ~SYNC_POL;
        end
    end

endmodule

// File: rtl/vga_timing_core.sv
// VGA raster timing generator: h/v axis counters, aligned blanking, sync and pulses.
// Optional frame counter built only when VGA_TIMING_FRAME_CNT_EN is defined.
module vga_timing_core
    import vga_timing_pkg::*;
#(
    parameter int   H_DISPLAY  = H_DISPLAY_DEF,
    parameter int   H_FRONT    = H_FRONT_DEF,
    parameter int   H_SYNC     = H_SYNC_DEF,
    parameter int   H_BACK     = H_BACK_DEF,
    parameter int   V_DISPLAY  = V_DISPLAY_DEF,
    parameter int   V_FRONT    = V_FRONT_DEF,
    parameter int   V_SYNC     = V_SYNC_DEF,
    parameter int   V_BACK     = V_BACK_DEF,
    parameter logic H_SYNC_POL = SYNC_ACTIVE_LOW,
    parameter logic V_SYNC_POL = SYNC_ACTIVE_LOW,
    parameter int   FRAME_W    = 10
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ce,
    output logic [POS_W-1:0]   hpos,
    output logic [POS_W-1:0]   vpos,
    output logic               display_on,
    output logic               hsync,
    output logic               vsync,
    output logic               line_start,
    output logic               frame_start,
    output logic [FRAME_W-1:0] frame_cnt
);

    logic             h_wrap, v_wrap, v_inc;
    logic [POS_W-1:0] h_next, v_next;

    assign v_inc = ce & h_wrap;

    vga_axis_counter #(
        .DISPLAY(H_DISPLAY), .FRONT(H_FRONT), .SYNC(H_SYNC), .BACK(H_BACK), .SYNC_POL(H_SYNC_POL)
    ) u_h_axis (
        .clk(clk), .rst_n(rst_n), .inc(ce),
        .pos(hpos), .pos_next(h_next), .wrap(h_wrap), .sync(hsync)
    );

    vga_axis_counter #(
        .DISPLAY(V_DISPLAY), .FRONT(V_FRONT), .SYNC(V_SYNC), .BACK(V_BACK), .SYNC_POL(V_SYNC_POL)
    ) u_v_axis (
        .clk(clk), .rst_n(rst_n), .inc(v_inc),
        .pos(vpos), .pos_next(v_next), .wrap(v_wrap), .sync(vsync)
    );

    // display_on only updates on ce so the blanked reset value holds until the first strobe
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            display_on  <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            line_start  <= h_wrap;
            frame_start <= v_wrap;
            if (ce)
                display_on <= (h_next < POS_W'(H_DISPLAY)) && (v_next < POS_W'(V_DISPLAY));
        end
    end

`ifdef VGA_TIMING_FRAME_CNT_EN
    localparam logic [POS_W-1:0] V_SYNC_START = POS_W'(V_DISPLAY + V_FRONT);

    logic [FRAME_W-1:0] frame_q;

    always_ff @(posedge clk) begin
        if (!rst_n)
            frame_q <= '0;
        else if (v_inc && v_next == V_SYNC_START)
            frame_q <= frame_q + 1'b1;
    end

    assign frame_cnt = frame_q;
`else
    assign frame_cnt = '0;
`endif

endmodule

// File: tb/tb_vga_timing_core.sv
// Randomised-ce bench for vga_timing_core on a shrunken raster; the reference
// derives every output from the count of ce strobes since reset.
module tb_vga_timing_core;

    localparam int HD = 10, HF = 2, HS = 3, HB = 4;
    localparam int VD = 6,  VF = 2, VS = 2, VB = 3;
    localparam int HT = HD + HF + HS + HB;
    localparam int VT = VD + VF + VS + VB;
    localparam int FT = HT * VT;
    localparam int FW = 2;
    localparam logic HPOL = 1'b0;
    localparam logic VPOL = 1'b1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          ce = 1'b0;
    logic [9:0]    hpos, vpos;
    logic          display_on, hsync, vsync, line_start, frame_start;
    logic [FW-1:0] frame_cnt;

    int   n;
    logic exp_ls, exp_fs;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    vga_timing_core #(
        .H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_DISPLAY(VD), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
        .H_SYNC_POL(HPOL), .V_SYNC_POL(VPOL), .FRAME_W(FW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .ce(ce),
        .hpos(hpos), .vpos(vpos), .display_on(display_on),
        .hsync(hsync), .vsync(vsync),
        .line_start(line_start), .frame_start(frame_start),
        .frame_cnt(frame_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d (strobes=%0d)", tag, obs, exp, n);
        end
    endtask

    task automatic check_all();
        int p, eh, ev, efc, s;
        logic ed, ehs, evs;
        p   = n % FT;
        eh  = p % HT;
        ev  = p / HT;
        ed  = (n != 0) && (eh < HD) && (ev < VD);
        ehs = (eh >= HD + HF && eh < HD + HF + HS) ? HPOL : ~HPOL;
        evs = (ev >= VD + VF && ev < VD + VF + VS) ? VPOL : ~VPOL;
        s   = (VD + VF) * HT;
`ifdef VGA_TIMING_FRAME_CNT_EN
        efc = (n >= s) ? (((n - s) / FT + 1) % (1 << FW)) : 0;
`else
        efc = 0;
`endif
        chk("hpos",        32'(hpos),        32'(eh));
        chk("vpos",        32'(vpos),        32'(ev));
        chk("display_on",  32'(display_on),  32'(ed));
        chk("hsync",       32'(hsync),       32'(ehs));
        chk("vsync",       32'(vsync),       32'(evs));
        chk("line_start",  32'(line_start),  32'(exp_ls));
        chk("frame_start", 32'(frame_start), 32'(exp_fs));
        chk("frame_cnt",   32'(frame_cnt),   32'(efc));
    endtask

    task automatic step(input logic r, input logic c);
        rst_n = r;
        ce    = c;
        @(posedge clk);
        if (!r) begin
            n = 0; exp_ls = 1'b0; exp_fs = 1'b0;
        end else if (c) begin
            n++;
            exp_ls = (n % HT == 0);
            exp_fs = (n % FT == 0);
        end else begin
            exp_ls = 1'b0; exp_fs = 1'b0;
        end
        #1 check_all();
    endtask

    initial begin
        n = 0; exp_ls = 1'b0; exp_fs = 1'b0;
        // reset regardless of ce, then hold with ce low
        repeat (3) step(1'b0, $urandom_range(0, 1) == 1);
        repeat (2) step(1'b1, 1'b0);
        // free-running two full frames
        repeat (2 * FT) step(1'b1, 1'b1);
        // random strobe pattern
        repeat (2 * FT) step(1'b1, $urandom_range(0, 1) == 1);
        // reset landing mid-frame, ce held high through it
        repeat ($urandom_range(20, 200)) step(1'b1, 1'b1);
        step(1'b0, 1'b1);
        repeat (FT) step(1'b1, 1'b1);
        // strict 1/0 alternation over one frame
        for (int i = 0; i < 2 * FT; i++) step(1'b1, (i % 2) == 0);
        // long mostly-on run to take the frame counter through its wrap
        step(1'b0, 1'b0);
        repeat (6 * FT) step(1'b1, $urandom_range(0, 4) != 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
